// File: rtl/neighbor_count_sequencer.sv
// neighbor_count_sequencer: time-multiplexed Life-rule evaluator; build option NEIGHBOR_SEQ_EARLY_EXIT_EN
module neighbor_count_sequencer #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int BIRTH_COUNT    = 3,
    parameter int SURVIVE_MIN    = 2,
    parameter int SURVIVE_MAX    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic [7:0] neighbors,
    input  logic       cell_alive,
    output logic       result_valid,
    input  logic       result_ready,
    output logic [3:0] count,
    output logic       next_alive,
    output logic       busy
);
    localparam int STEPS = 8 / BITS_PER_CYCLE;
`ifdef NEIGHBOR_SEQ_EARLY_EXIT_EN
    localparam int EXIT_LIMIT = (BIRTH_COUNT > SURVIVE_MAX) ? BIRTH_COUNT : SURVIVE_MAX;
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t     state;
    logic [7:0] shift;
    logic [3:0] acc;
    logic [3:0] acc_next;
    logic [3:0] step;
    logic       alive;
    logic       leave_accum;

    // next accumulator value and whether this accumulate step is the final one
    always_comb begin
        acc_next = acc + 4'($countones(shift[BITS_PER_CYCLE-1:0]));
`ifdef NEIGHBOR_SEQ_EARLY_EXIT_EN
        leave_accum = (step == 4'(STEPS - 1)) || (acc_next > 4'(EXIT_LIMIT));
`else
        leave_accum = step == 4'(STEPS - 1);
`endif
    end

    // sequencer FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shift        <= '0;
            acc          <= '0;
            step         <= '0;
            alive        <= 1'b0;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
            count        <= '0;
            next_alive   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_valid && start_ready) begin
                    shift       <= neighbors;
                    alive       <= cell_alive;
                    acc         <= '0;
                    step        <= '0;
                    start_ready <= 1'b0;
                    busy        <= 1'b1;
                    state       <= ACCUM;
                end
                ACCUM: begin
                    acc   <= acc_next;
                    shift <= shift >> BITS_PER_CYCLE;
                    step  <= step + 4'd1;
                    if (leave_accum) state <= RESOLVE;
                end
                RESOLVE: begin
                    count        <= acc;
                    next_alive   <= (acc == 4'(BIRTH_COUNT)) |
                                    (alive & (acc >= 4'(SURVIVE_MIN)) & (acc <= 4'(SURVIVE_MAX)));
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: if (result_ready) begin
                    result_valid <= 1'b0;
                    start_ready  <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neighbor_count_sequencer.sv
// tb_neighbor_count_sequencer: directed self-checking bench for neighbor_count_sequencer
module tb_neighbor_count_sequencer;
    logic       clk = 0, reset = 1, start_valid = 0, cell_alive = 0, result_ready = 0;
    logic [7:0] neighbors = '0;
    logic       start_ready, result_valid, next_alive, busy;
    logic [3:0] count;
    int checks = 0, failures = 0;

`ifdef NEIGHBOR_SEQ_EARLY_EXIT_EN
    localparam int FF_COUNT = 4, FF_LAT = 6, F0_LAT = 6;
`else
    localparam int FF_COUNT = 8, FF_LAT = 10, F0_LAT = 10;
`endif

    neighbor_count_sequencer dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .neighbors(neighbors), .cell_alive(cell_alive), .result_valid(result_valid),
        .result_ready(result_ready), .count(count), .next_alive(next_alive), .busy(busy)
    );

    always #5 clk = ~clk;

    // present a request while idle; lat counts edges from the accept edge (1) to the edge raising result_valid
    task automatic run(input logic [7:0] n, input logic a, output int lat);
        @(negedge clk);
        neighbors = n; cell_alive = a; start_valid = 1;
        @(posedge clk); #1;
        start_valid = 0; neighbors = ~n; cell_alive = ~a;
        lat = 1;
        while (!result_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_result(input string tag);
        @(negedge clk); result_ready = 1;
        @(posedge clk); #1; result_ready = 0;
        checks++; if (result_valid !== 0 || start_ready !== 1 || busy !== 0) begin failures++; $display("FAIL %s_release got rv=%b rdy=%b busy=%b want rv=0 rdy=1 busy=0", tag, result_valid, start_ready, busy); end
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_lat, input logic [3:0] exp_cnt, input logic exp_na);
        checks++; if (lat != exp_lat) begin failures++; $display("FAIL %s_latency got=%0d want=%0d", tag, lat, exp_lat); end
        checks++; if (count !== exp_cnt) begin failures++; $display("FAIL %s_count got=%0d want=%0d", tag, count, exp_cnt); end
        checks++; if (next_alive !== exp_na) begin failures++; $display("FAIL %s_next_alive got=%b want=%b", tag, next_alive, exp_na); end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (start_ready !== 1 || result_valid !== 0 || busy !== 0 || count !== 0 || next_alive !== 0) begin failures++; $display("FAIL reset_in got rdy=%b rv=%b busy=%b cnt=%0d na=%b want 1 0 0 0 0", start_ready, result_valid, busy, count, next_alive); end
        @(negedge clk); reset = 0;
        repeat (2) @(posedge clk); #1;
        checks++; if (start_ready !== 1 || result_valid !== 0 || busy !== 0 || count !== 0) begin failures++; $display("FAIL reset_idle got rdy=%b rv=%b busy=%b cnt=%0d want 1 0 0 0", start_ready, result_valid, busy, count); end
    endtask

    task automatic test_birth();
        int lat;
        result_ready = 1;
        run(8'b0000_0111, 0, lat);
        result_ready = 0;
        check_result("birth", lat, 10, 4'd3, 1'b1);
        release_result("birth");
        run(8'b0101_0100, 1, lat);
        check_result("survive3", lat, 10, 4'd3, 1'b1);
        release_result("survive3");
    endtask

    task automatic test_survive();
        int lat;
        run(8'b1000_0001, 1, lat);
        check_result("survive2", lat, 10, 4'd2, 1'b1);
        release_result("survive2");
        run(8'b1000_0001, 0, lat);
        check_result("dead2", lat, 10, 4'd2, 1'b0);
        release_result("dead2");
        run(8'h00, 1, lat);
        check_result("zero", lat, 10, 4'd0, 1'b0);
        release_result("zero");
    endtask

    task automatic test_full();
        int lat;
        run(8'hFF, 1, lat);
        check_result("full", lat, FF_LAT, 4'(FF_COUNT), 1'b0);
        release_result("full");
    endtask

    task automatic test_hold();
        int lat;
        run(8'h0A, 1, lat);
        check_result("hold", lat, 10, 4'd2, 1'b1);
        @(negedge clk);
        start_valid = 1; neighbors = 8'h01; cell_alive = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (result_valid !== 1 || count !== 4'd2 || next_alive !== 1 || start_ready !== 0 || busy !== 1) begin failures++; $display("FAIL hold_cycle%0d got rv=%b cnt=%0d na=%b rdy=%b busy=%b want 1 2 1 0 1", i, result_valid, count, next_alive, start_ready, busy); end
        end
        @(negedge clk); result_ready = 1;
        @(posedge clk); #1; result_ready = 0;
        checks++; if (result_valid !== 0 || start_ready !== 1 || busy !== 0 || count !== 4'd2) begin failures++; $display("FAIL hold_to_idle got rv=%b rdy=%b busy=%b cnt=%0d want 0 1 0 2", result_valid, start_ready, busy, count); end
        @(posedge clk); #1;
        start_valid = 0; neighbors = 8'hFF; cell_alive = 1;
        checks++; if (busy !== 1 || start_ready !== 0) begin failures++; $display("FAIL hold_accept got busy=%b rdy=%b want 1 0", busy, start_ready); end
        lat = 1;
        while (!result_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check_result("after_hold", lat, 10, 4'd1, 1'b0);
        release_result("after_hold");
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        neighbors = 8'hFF; cell_alive = 1; start_valid = 1;
        @(posedge clk); #1; start_valid = 0;
        repeat (4) @(posedge clk);
        #2 reset = 1;
        #1;
        checks++; if (start_ready !== 1 || result_valid !== 0 || busy !== 0 || count !== 0) begin failures++; $display("FAIL midreset_async got rdy=%b rv=%b busy=%b cnt=%0d want 1 0 0 0", start_ready, result_valid, busy, count); end
        @(negedge clk); reset = 0;
        @(posedge clk); #1;
        checks++; if (start_ready !== 1 || result_valid !== 0 || busy !== 0) begin failures++; $display("FAIL midreset_next got rdy=%b rv=%b busy=%b want 1 0 0", start_ready, result_valid, busy); end
        run(8'h0F, 0, lat);
        check_result("midreset_new", lat, F0_LAT, 4'd4, 1'b0);
        release_result("midreset_new");
    endtask

    initial begin
        test_reset();
        test_birth();
        test_survive();
        test_full();
        test_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
